uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_sync2.sv | 28 ++
 rtl/uart_rx.sv | 149 ++++++++++++++
 tb/tb_uart_rx.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: receiver state encoding, default frame geometry and parity modes.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_DATA_WIDTH = 8;

  localparam bit PARITY_EVEN = 1'b0;
  localparam bit PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous single-bit inputs (rx, cts, ...).
module uart_sync2
  import uart_pkg::*;
#(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start qualification, LSB-first data, optional parity, stop check.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = PARITY_EVEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_tick,
  input  logic                  rx_data_in,
  output logic [DATA_WIDTH-1:0] rx_data_out,
  output logic                  rx_valid,
  output logic                  parity_error,
  output logic                  framing_error,
  output logic                  rx_busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  logic rx_s;

  uart_sync2 #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d_i(rx_data_in),
    .q_o(rx_s)
  );

  rx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic [BIT_W-1:0]      bit_q,   bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  perr_q,  perr_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic                  valid_q, valid_d;
  logic                  pe_q,    pe_d;
  logic                  fe_q,    fe_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
    end
  end

  // Every decision is gated by sample_tick, so a tick gap freezes the whole receiver.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    data_d  = data_q;
    valid_d = 1'b0;
    pe_d    = pe_q;
    fe_d    = fe_q;
    if (sample_tick) begin
      cnt_d = cnt_q + 1'b1;
      unique case (state_q)
        RX_IDLE: begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = RX_START;
            perr_d  = 1'b0;
          end
        end
        RX_START: begin
          if (cnt_q == CNT_MID) begin
            cnt_d   = '0;
            bit_d   = '0;
            state_d = rx_s ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d          = '0;
            shift_d[bit_q] = rx_s;
            if (bit_q == BIT_LAST) begin
              state_d = PARITY_EN ? RX_PARITY : RX_STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
        RX_PARITY: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            perr_d  = rx_s != ((^shift_q) ^ PARITY_ODD);
            state_d = RX_STOP;
          end
        end
        RX_STOP: begin
          // Returning to IDLE at mid-stop leaves half a bit to catch an immediately following start.
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            valid_d = 1'b1;
            data_d  = shift_q;
            pe_d    = perr_q;
            fe_d    = !rx_s;
            state_d = rx_s ? RX_IDLE : RX_BREAK;
          end
        end
        RX_BREAK: begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = RX_IDLE;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = RX_IDLE;
        end
      endcase
    end
  end

  assign rx_data_out   = data_q;
  assign rx_valid      = valid_q;
  assign parity_error  = pe_q;
  assign framing_error = fe_q;
  assign rx_busy       = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: parity and no-parity instances, scoreboard of expected frames vs. received pulses.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_tick;
  logic       rx_a, rx_b;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       perr_a, perr_b;
  logic       ferr_a, ferr_b;
  logic       busy_a, busy_b;

  uart_rx #(
    .DATA_WIDTH(8), .OVERSAMPLE(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)
  ) dut_a (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .rx_data_in(rx_a),
    .rx_data_out(data_a), .rx_valid(valid_a), .parity_error(perr_a),
    .framing_error(ferr_a), .rx_busy(busy_a)
  );

  uart_rx #(
    .DATA_WIDTH(8), .OVERSAMPLE(16), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .rx_data_in(rx_b),
    .rx_data_out(data_b), .rx_valid(valid_b), .parity_error(perr_b),
    .framing_error(ferr_b), .rx_busy(busy_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       fe;
  } rx_word_t;

  rx_word_t exp_a[$], exp_b[$], got_a[$], got_b[$];
  time      got_ta[$], got_tb[$];
  time      stop_t;
  int       errors = 0;
  int       checks = 0;

  // One tick every 4 clocks, driven on the falling edge.
  initial begin
    sample_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (valid_a === 1'b1) begin
      got_a.push_back({data_a, perr_a, ferr_a});
      got_ta.push_back($time);
    end
    if (valid_b === 1'b1) begin
      got_b.push_back({data_b, perr_b, ferr_b});
      got_tb.push_back($time);
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic set_line(input bit which, input logic v);
    if (which) rx_b = v;
    else       rx_a = v;
  endtask

  task automatic send_bit(input bit which, input logic v);
    set_line(which, v);
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame(input bit which, input logic [7:0] d, input bit with_par,
                            input logic par, input logic stop);
    send_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(which, d[i]);
    if (with_par) send_bit(which, par);
    stop_t = $time;
    send_bit(which, stop);
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    rx_a = 1'b1;
    rx_b = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (data_a !== 8'h00) begin errors++; $display("FAIL reset_data_a: got %h want 00", data_a); end
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid_a: got %b want 0", valid_a); end
    checks++; if (perr_a !== 1'b0) begin errors++; $display("FAIL reset_perr_a: got %b want 0", perr_a); end
    checks++; if (ferr_a !== 1'b0) begin errors++; $display("FAIL reset_ferr_a: got %b want 0", ferr_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy_a: got %b want 0", busy_a); end
    checks++; if (data_b !== 8'h00) begin errors++; $display("FAIL reset_data_b: got %h want 00", data_b); end
    checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL reset_busy_b: got %b want 0", busy_b); end
  endtask

  task automatic test_good_frame();
    rx_word_t e, g;
    time      t;
    exp_a.push_back({8'hA5, 1'b0, 1'b0});
    send_frame(1'b0, 8'hA5, 1'b1, 1'b0, 1'b1);
    repeat (BIT_CLK) @(negedge clk);
    checks++;
    if (got_a.size() !== 1) begin
      errors++; $display("FAIL good_count: got %0d pulses want 1", got_a.size());
      exp_a.delete(); got_a.delete(); got_ta.delete();
    end else begin
      e = exp_a.pop_front(); g = got_a.pop_front(); t = got_ta.pop_front();
      checks++; if (g.data !== e.data) begin errors++; $display("FAIL good_data: got %h want %h", g.data, e.data); end
      checks++; if (g.pe !== e.pe) begin errors++; $display("FAIL good_perr: got %b want %b", g.pe, e.pe); end
      checks++; if (g.fe !== e.fe) begin errors++; $display("FAIL good_ferr: got %b want %b", g.fe, e.fe); end
      checks++;
      if (t < stop_t + 300 || t > stop_t + 450) begin
        errors++; $display("FAIL good_latency: valid %0t ns after stop start, want 300..450", t - stop_t);
      end
    end
  endtask

  task automatic test_parity_error();
    rx_word_t e, g;
    exp_a.push_back({8'h3C, 1'b1, 1'b0});
    send_frame(1'b0, 8'h3C, 1'b1, 1'b1, 1'b1);
    repeat (BIT_CLK) @(negedge clk);
    checks++;
    if (got_a.size() !== 1) begin
      errors++; $display("FAIL par_count: got %0d pulses want 1", got_a.size());
      exp_a.delete(); got_a.delete(); got_ta.delete();
    end else begin
      e = exp_a.pop_front(); g = got_a.pop_front(); void'(got_ta.pop_front());
      checks++; if (g.data !== e.data) begin errors++; $display("FAIL par_data: got %h want %h", g.data, e.data); end
      checks++; if (g.pe !== e.pe) begin errors++; $display("FAIL par_perr: got %b want %b", g.pe, e.pe); end
      checks++; if (g.fe !== e.fe) begin errors++; $display("FAIL par_ferr: got %b want %b", g.fe, e.fe); end
    end
    checks++; if (perr_a !== 1'b1) begin errors++; $display("FAIL par_persist: got %b want 1", perr_a); end
  endtask

  task automatic test_break();
    rx_word_t e, g;
    int       busy_lo = 0;
    exp_a.push_back({8'h55, 1'b0, 1'b1});
    send_frame(1'b0, 8'h55, 1'b1, 1'b0, 1'b0);
    repeat (3 * BIT_CLK) begin
      @(negedge clk);
      if (busy_a !== 1'b1) busy_lo++;
    end
    checks++; if (busy_lo !== 0) begin errors++; $display("FAIL break_busy: busy low for %0d clk want 0", busy_lo); end
    set_line(1'b0, 1'b1);
    repeat (2 * BIT_CLK) @(negedge clk);
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL break_idle: busy %b want 0", busy_a); end
    checks++;
    if (got_a.size() !== 1) begin
      errors++; $display("FAIL break_count: got %0d pulses want 1", got_a.size());
      exp_a.delete(); got_a.delete(); got_ta.delete();
    end else begin
      e = exp_a.pop_front(); g = got_a.pop_front(); void'(got_ta.pop_front());
      checks++; if (g.data !== e.data) begin errors++; $display("FAIL break_data: got %h want %h", g.data, e.data); end
      checks++; if (g.pe !== e.pe) begin errors++; $display("FAIL break_perr: got %b want %b", g.pe, e.pe); end
      checks++; if (g.fe !== e.fe) begin errors++; $display("FAIL break_ferr: got %b want %b", g.fe, e.fe); end
    end
  endtask

  task automatic test_glitch();
    bit busy_seen = 1'b0;
    set_line(1'b0, 1'b0);
    repeat (16) begin
      @(negedge clk);
      if (busy_a === 1'b1) busy_seen = 1'b1;
    end
    set_line(1'b0, 1'b1);
    repeat (BIT_CLK - 16) begin
      @(negedge clk);
      if (busy_a === 1'b1) busy_seen = 1'b1;
    end
    checks++; if (busy_seen !== 1'b1) begin errors++; $display("FAIL glitch_busy_seen: got %b want 1", busy_seen); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b want 0", busy_a); end
    repeat (BIT_CLK) @(negedge clk);
    checks++; if (got_a.size() !== 0) begin errors++; $display("FAIL glitch_valid: got %0d pulses want 0", got_a.size()); got_a.delete(); got_ta.delete(); end
    checks++; if (ferr_a !== 1'b1) begin errors++; $display("FAIL glitch_flag_hold: ferr %b want 1", ferr_a); end
  endtask

  task automatic test_back_to_back();
    rx_word_t e, g;
    time      t0, t1;
    exp_b.push_back({8'h01, 1'b0, 1'b0});
    exp_b.push_back({8'hFF, 1'b0, 1'b0});
    send_frame(1'b1, 8'h01, 1'b0, 1'b0, 1'b1);
    send_frame(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
    repeat (BIT_CLK) @(negedge clk);
    checks++;
    if (got_b.size() !== 2) begin
      errors++; $display("FAIL b2b_count: got %0d pulses want 2", got_b.size());
      exp_b.delete(); got_b.delete(); got_tb.delete();
    end else begin
      t0 = got_tb.pop_front(); t1 = got_tb.pop_front();
      for (int k = 0; k < 2; k++) begin
        e = exp_b.pop_front(); g = got_b.pop_front();
        checks++; if (g.data !== e.data) begin errors++; $display("FAIL b2b_data%0d: got %h want %h", k, g.data, e.data); end
        checks++; if ({g.pe, g.fe} !== {e.pe, e.fe}) begin errors++; $display("FAIL b2b_flags%0d: got %b%b want %b%b", k, g.pe, g.fe, e.pe, e.fe); end
      end
      checks++;
      if (t1 < t0 + 6360 || t1 > t0 + 6440) begin
        errors++; $display("FAIL b2b_spacing: got %0t ns want 6400 +/- 40", t1 - t0);
      end
    end
  endtask

  task automatic test_mid_reset();
    rx_word_t e, g;
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    set_line(1'b0, 1'b0);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_line(1'b0, 1'b1);
    checks++; if (data_a !== 8'h00) begin errors++; $display("FAIL mrst_data: got %h want 00", data_a); end
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL mrst_valid: got %b want 0", valid_a); end
    checks++; if (perr_a !== 1'b0) begin errors++; $display("FAIL mrst_perr: got %b want 0", perr_a); end
    checks++; if (ferr_a !== 1'b0) begin errors++; $display("FAIL mrst_ferr: got %b want 0", ferr_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL mrst_busy: got %b want 0", busy_a); end
    repeat (2 * BIT_CLK) @(negedge clk);
    checks++; if (got_a.size() !== 0) begin errors++; $display("FAIL mrst_valid_count: got %0d pulses want 0", got_a.size()); got_a.delete(); got_ta.delete(); end
    exp_a.push_back({8'h7E, 1'b0, 1'b0});
    send_frame(1'b0, 8'h7E, 1'b1, 1'b0, 1'b1);
    repeat (BIT_CLK) @(negedge clk);
    checks++;
    if (got_a.size() !== 1) begin
      errors++; $display("FAIL mrst_next_count: got %0d pulses want 1", got_a.size());
      exp_a.delete(); got_a.delete(); got_ta.delete();
    end else begin
      e = exp_a.pop_front(); g = got_a.pop_front(); void'(got_ta.pop_front());
      checks++; if (g.data !== e.data) begin errors++; $display("FAIL mrst_next_data: got %h want %h", g.data, e.data); end
      checks++; if ({g.pe, g.fe} !== {e.pe, e.fe}) begin errors++; $display("FAIL mrst_next_flags: got %b%b want %b%b", g.pe, g.fe, e.pe, e.fe); end
    end
  endtask

  initial begin
    rst  = 1'b1;
    rx_a = 1'b1;
    rx_b = 1'b1;
    @(negedge clk);
    test_reset();
    repeat (BIT_CLK) @(negedge clk);
    test_good_frame();
    test_parity_error();
    test_break();
    test_glitch();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
